lcd_cmd_sequencer: RTL and testbench

//  Buffers image-processing commands from a host and issues them one at a time
//  to the 8x8 LCD image engine (cmd/cmd_valid/busy/done interface).

---
 rtl/lcd_cmd_sequencer_if.sv | 20 ++
 rtl/lcd_cmd_sequencer.sv | 140 ++++++++++++++
 tb/tb_lcd_cmd_sequencer.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_cmd_sequencer_if.sv
// rtl/lcd_cmd_sequencer_if.sv - host push and LCD engine handshake bundle for lcd_cmd_sequencer
interface lcd_cmd_sequencer_if;
    logic [3:0] host_cmd;
    logic       host_valid;
    logic       host_ready;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;

    modport master (
        output host_cmd, host_valid, lcd_busy, lcd_done,
        input  host_ready, lcd_cmd, lcd_cmd_valid
    );

    modport slave (
        input  host_cmd, host_valid, lcd_busy, lcd_done,
        output host_ready, lcd_cmd, lcd_cmd_valid
    );
endinterface

// File: rtl/lcd_cmd_sequencer.sv
// rtl/lcd_cmd_sequencer.sv - command FIFO and issue FSM for the 8x8 LCD image engine
// Optional issue counter enabled by defining SEQ_STATS_EN.
module lcd_cmd_sequencer #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    lcd_cmd_sequencer_if.slave  bus,
    output logic [AW:0]         o_fifo_level,
    output logic                o_seq_idle,
    output logic                o_err_illegal,
    output logic                o_finished,
    output logic [15:0]         o_issued_cnt
);

    typedef enum logic [2:0] {
        S_INIT_HI,
        S_INIT_LO,
        S_IDLE,
        S_ISSUE,
        S_GUARD,
        S_WAIT,
        S_FLUSH,
        S_DONE
    } state_t;

    localparam logic [AW:0]   FULL_LVL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    state_t          r_state;
    logic [3:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_level;
    logic [3:0]      r_lcd_cmd;
    logic            r_lcd_cmd_valid;
    logic            r_err_illegal;
    logic            r_finished;

    logic            w_full;
    logic            w_empty;
    logic            w_host_ready;
    logic            w_offer;
    logic            w_push;
    logic            w_illegal;
    logic            w_pop;

    assign w_full       = (r_level == FULL_LVL);
    assign w_empty      = (r_level == '0);
    assign w_host_ready = !w_full && (r_state != S_DONE);
    assign w_offer      = bus.host_valid && w_host_ready;
    assign w_push       = w_offer && (bus.host_cmd <= 4'd11);
    assign w_illegal    = w_offer && (bus.host_cmd >= 4'd12);
    assign w_pop        = (r_state == S_ISSUE);

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.host_cmd;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= S_INIT_HI;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_level         <= '0;
            r_lcd_cmd       <= 4'd0;
            r_lcd_cmd_valid <= 1'b0;
            r_err_illegal   <= 1'b0;
            r_finished      <= 1'b0;
        end else begin
            r_err_illegal   <= w_illegal;
            r_lcd_cmd_valid <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_ONE;
                2'b01:   r_level <= r_level - LVL_ONE;
                default: r_level <= r_level;
            endcase

            case (r_state)
                S_INIT_HI: if (bus.lcd_busy)  r_state <= S_INIT_LO;
                S_INIT_LO: if (!bus.lcd_busy) r_state <= S_IDLE;
                S_IDLE: begin
                    // Strobe and opcode are registered together so ISSUE presents both.
                    if (!w_empty && !bus.lcd_busy) begin
                        r_state         <= S_ISSUE;
                        r_lcd_cmd_valid <= 1'b1;
                        r_lcd_cmd       <= r_mem[r_rd_ptr];
                    end
                end
                S_ISSUE:   r_state <= (r_lcd_cmd == 4'd0) ? S_FLUSH : S_GUARD;
                S_GUARD:   r_state <= S_WAIT;
                S_WAIT:    if (!bus.lcd_busy) r_state <= S_IDLE;
                S_FLUSH: begin
                    if (bus.lcd_done) begin
                        r_state    <= S_DONE;
                        r_finished <= 1'b1;
                    end
                end
                S_DONE:    r_state <= S_DONE;
                default:   r_state <= S_INIT_HI;
            endcase
        end
    end

`ifdef SEQ_STATS_EN
    logic [15:0] r_issued_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_issued_cnt <= 16'h0000;
        end else if (w_pop && (r_issued_cnt != 16'hFFFF)) begin
            r_issued_cnt <= r_issued_cnt + 16'h0001;
        end
    end

    assign o_issued_cnt = r_issued_cnt;
`else
    assign o_issued_cnt = 16'h0000;
`endif

    assign bus.host_ready    = w_host_ready;
    assign bus.lcd_cmd       = r_lcd_cmd;
    assign bus.lcd_cmd_valid = r_lcd_cmd_valid;
    assign o_fifo_level      = r_level;
    assign o_seq_idle        = (r_state == S_IDLE) && w_empty;
    assign o_err_illegal     = r_err_illegal;
    assign o_finished        = r_finished;

endmodule

// File: tb/tb_lcd_cmd_sequencer.sv
// tb/tb_lcd_cmd_sequencer.sv - directed self-checking bench for lcd_cmd_sequencer
module tb_lcd_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  fifo_level;
    logic        seq_idle;
    logic        err_illegal;
    logic        finished;
    logic [15:0] issued_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    lcd_cmd_sequencer_if bus ();

    lcd_cmd_sequencer #(.DEPTH(16), .AW(4)) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .bus           (bus),
        .o_fifo_level  (fifo_level),
        .o_seq_idle    (seq_idle),
        .o_err_illegal (err_illegal),
        .o_finished    (finished),
        .o_issued_cnt  (issued_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int          n_valid;
        int          bcnt;
        int          k;
        bit          stop;
        logic [3:0]  got[$];
        logic [3:0]  e4[3];
        logic [3:0]  t2[16];

        e4 = '{4'd5, 4'd7, 4'd0};
        for (int i = 0; i < 16; i++) t2[i] = (i == 15) ? 4'd0 : 4'((i % 11) + 1);

        reset          = 1'b1;
        bus.host_cmd   = 4'd0;
        bus.host_valid = 1'b0;
        bus.lcd_busy   = 1'b0;
        bus.lcd_done   = 1'b0;
        repeat (2) tick();

        chk("rst_level", fifo_level, 0);
        chk("rst_host_ready", bus.host_ready, 1);
        chk("rst_cmd_valid", bus.lcd_cmd_valid, 0);
        chk("rst_lcd_cmd", bus.lcd_cmd, 0);
        chk("rst_seq_idle", seq_idle, 0);
        chk("rst_err", err_illegal, 0);
        chk("rst_finished", finished, 0);
        chk("rst_issued", issued_cnt, 0);

        // Illegal opcode during the image load
        reset          = 1'b0;
        bus.lcd_busy   = 1'b1;
        bus.host_valid = 1'b1;
        bus.host_cmd   = 4'd13;
        tick();
        bus.host_valid = 1'b0;
        chk("t3_err_pulse", err_illegal, 1);
        chk("t3_level", fifo_level, 0);
        tick();
        chk("t3_err_clear", err_illegal, 0);

        n_valid = 0;
        repeat (62) begin
            tick();
            if (bus.lcd_cmd_valid) n_valid++;
        end
        bus.lcd_busy = 1'b0;
        tick();
        chk("t1_no_issue_in_init", n_valid, 0);
        chk("t1_idle_after_load", seq_idle, 1);

        bus.host_valid = 1'b1;
        bus.host_cmd   = 4'd4;
        tick();
        bus.host_valid = 1'b0;
        chk("t1_no_early_strobe", bus.lcd_cmd_valid, 0);
        chk("t1_level_one", fifo_level, 1);
        tick();
        chk("t1_strobe", bus.lcd_cmd_valid, 1);
        chk("t1_cmd", bus.lcd_cmd, 4);
        tick();
        chk("t1_strobe_one_cycle", bus.lcd_cmd_valid, 0);
        chk("t1_level_zero", fifo_level, 0);
        tick();
        tick();
        chk("t1_seq_idle", seq_idle, 1);
        chk("t1_cmd_held", bus.lcd_cmd, 4);
`ifdef SEQ_STATS_EN
        chk("t1_issued", issued_cnt, 1);
`else
        chk("t1_issued_tied", issued_cnt, 0);
`endif

        // Paced issue with an engine that stays busy 3 cycles per strobe
        bcnt = 0;
        for (int c = 0; c < 100 && got.size() < 3; c++) begin
            if (c < 3) begin
                bus.host_valid = 1'b1;
                bus.host_cmd   = e4[c];
            end else begin
                bus.host_valid = 1'b0;
            end
            tick();
            if (bus.lcd_cmd_valid) begin
                chk("t4_busy_low_at_issue", bus.lcd_busy, 0);
                got.push_back(bus.lcd_cmd);
                bcnt = 3;
            end
            bus.lcd_busy = (bcnt > 0);
            if (bcnt > 0) bcnt--;
        end
        bus.host_valid = 1'b0;
        chk("t4_strobe_count", got.size(), 3);
        for (int i = 0; i < got.size() && i < 3; i++) chk("t4_order", got[i], e4[i]);

        bus.lcd_busy   = 1'b0;
        bus.host_valid = 1'b1;
        bus.host_cmd   = 4'd3;
        tick();
        bus.host_valid = 1'b0;
        chk("t4_flush_not_finished", finished, 0);
        chk("t4_flush_accepts_push", fifo_level, 1);
        bus.lcd_done = 1'b1;
        tick();
        bus.lcd_done = 1'b0;
        chk("t4_finished", finished, 1);
        chk("t4_done_not_ready", bus.host_ready, 0);
`ifdef SEQ_STATS_EN
        chk("t4_issued", issued_cnt, 4);
`else
        chk("t4_issued_tied", issued_cnt, 0);
`endif
        bus.host_valid = 1'b1;
        bus.host_cmd   = 4'd2;
        tick();
        bus.host_valid = 1'b0;
        chk("t4_done_holds_fifo", fifo_level, 1);
        tick();
        chk("t4_finished_sticky", finished, 1);
        chk("t4_no_issue_in_done", bus.lcd_cmd_valid, 0);

        // Second session: fill the FIFO while still in INIT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("s2_rst_level", fifo_level, 0);
        chk("s2_rst_finished", finished, 0);
        chk("s2_rst_ready", bus.host_ready, 1);

        n_valid = 0;
        for (int i = 0; i < 16; i++) begin
            bus.host_valid = 1'b1;
            bus.host_cmd   = t2[i];
            tick();
            if (bus.lcd_cmd_valid) n_valid++;
        end
        bus.host_cmd = 4'd9;
        chk("t2_full_level", fifo_level, 16);
        chk("t2_full_not_ready", bus.host_ready, 0);
        repeat (4) begin
            tick();
            if (bus.lcd_cmd_valid) n_valid++;
        end
        chk("t2_full_level_held", fifo_level, 16);
        chk("t2_no_issue", n_valid, 0);

        bus.lcd_busy = 1'b1;
        tick();
        bus.lcd_busy = 1'b0;
        tick();
        chk("t5_idle_no_strobe", bus.lcd_cmd_valid, 0);
        tick();
        chk("t5_strobe", bus.lcd_cmd_valid, 1);
        chk("t5_head", bus.lcd_cmd, t2[0]);
        chk("t5_level_at_issue", fifo_level, 16);
        chk("t5_not_ready_at_issue", bus.host_ready, 0);
        tick();
        chk("t5_level_after_pop", fifo_level, 15);
        chk("t5_ready_after_pop", bus.host_ready, 1);
        tick();
        bus.host_valid = 1'b0;
        chk("t5_refill", fifo_level, 16);

        k    = 1;
        stop = 1'b0;
        for (int c = 0; c < 200 && !stop; c++) begin
            tick();
            if (bus.lcd_cmd_valid) begin
                if (k > 15) begin
                    chk("t5_extra_strobe", bus.lcd_cmd_valid, 0);
                    stop = 1'b1;
                end else begin
                    chk("t5_drain_order", bus.lcd_cmd, t2[k]);
                    if (t2[k] == 4'd0) stop = 1'b1;
                    else k++;
                end
            end
        end
        chk("t5_drain_count", k, 15);
        tick();
        chk("t5_last_held", fifo_level, 1);
        chk("t5_flush_not_finished", finished, 0);
`ifdef SEQ_STATS_EN
        chk("t5_issued", issued_cnt, 16);
`else
        chk("t5_issued_tied", issued_cnt, 0);
`endif

        // Reset while in FLUSH aborts the session
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t6_finished", finished, 0);
        chk("t6_level", fifo_level, 0);
        chk("t6_seq_idle", seq_idle, 0);
        chk("t6_ready", bus.host_ready, 1);
        chk("t6_issued", issued_cnt, 0);

        bus.host_valid = 1'b1;
        bus.host_cmd   = 4'd6;
        tick();
        bus.host_valid = 1'b0;
        n_valid = 0;
        repeat (8) begin
            tick();
            if (bus.lcd_cmd_valid) n_valid++;
        end
        chk("t6_waits_fresh_load", n_valid, 0);
        chk("t6_level_queued", fifo_level, 1);
        bus.lcd_busy = 1'b1;
        tick();
        bus.lcd_busy = 1'b0;
        tick();
        tick();
        chk("t6_issue_after_load", bus.lcd_cmd_valid, 1);
        chk("t6_cmd", bus.lcd_cmd, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
